// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_pkg                                                              |
// | Shared fixed-point widths, Q16.16 constants and twiddles for the FFT |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fft_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAC_W    = 16;
    localparam int INT_W     = DATA_W - FRAC_W;
    localparam int DEFAULT_N = 16;

    localparam logic [DATA_W-1:0] ONE  = 32'h0001_0000;
    localparam logic [DATA_W-1:0] ZERO = 32'h0000_0000;

    // Twiddles W_N^0 = 1 and W_N^(N/4) = -j, enough for the radix-2 front stages
    localparam logic [DATA_W-1:0] W0_RE   = ONE;
    localparam logic [DATA_W-1:0] W0_IM   = ZERO;
    localparam logic [DATA_W-1:0] WQTR_RE = ZERO;
    localparam logic [DATA_W-1:0] WQTR_IM = 32'hFFFF_0000;

    function automatic logic [DATA_W-1:0] q16_from_int(input logic [INT_W-1:0] v);
        return {v, {FRAC_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_frame_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_frame_loader_if                                                  |
// | Sample input stream and butterfly-pair output stream of the loader   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fft_frame_loader_if
    import fft_pkg::*;
#(
    parameter int IN_W = 16
) ();

    logic              in_valid;
    logic [IN_W-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_0_real;
    logic [DATA_W-1:0] data_0_imag;
    logic [DATA_W-1:0] data_1_real;
    logic [DATA_W-1:0] data_1_imag;
    logic              out_first;
    logic              out_last;
    logic              overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, data_0_real, data_0_imag, data_1_real, data_1_imag,
        input  out_first, out_last, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, data_0_real, data_0_imag, data_1_real, data_1_imag,
        output out_first, out_last, overflow
    );

endinterface
`default_nettype wire

// File: rtl/fft_bank_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_bank_ram                                                         |
// | Two N-entry sample banks, one write port, paired registered reads    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fft_bank_ram #(
    parameter int N = 16,
    parameter int W = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_wr_en,
    input  wire logic                   i_wr_bank,
    input  wire logic [$clog2(N)-1:0]   i_wr_addr,
    input  wire logic [W-1:0]           i_wr_data,
    input  wire logic                   i_rd_en,
    input  wire logic                   i_rd_bank,
    input  wire logic [$clog2(N)-2:0]   i_rd_addr,
    output logic      [W-1:0]           o_rd_data_0,
    output logic      [W-1:0]           o_rd_data_1
);

    logic [W-1:0] r_mem [0:2*N-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
    end

    // N is a power of two, so k + N/2 is k with the top address bit set
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rd_data_0 <= '0;
            o_rd_data_1 <= '0;
        end else if (i_rd_en) begin
            o_rd_data_0 <= r_mem[{i_rd_bank, 1'b0, i_rd_addr}];
            o_rd_data_1 <= r_mem[{i_rd_bank, 1'b1, i_rd_addr}];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_frame_loader                                                     |
// | Ping-pong frame buffer feeding (x[k], x[k+N/2]) pairs to stage one   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int IN_W = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fft_frame_loader_if.slave bus
);

    localparam int c_AW = $clog2(N);
    localparam int c_KW = c_AW - 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOAD   = 2'd1;
    localparam logic [1:0] c_ST_STREAM = 2'd2;

    logic [c_AW-1:0] r_wr_ptr;
    logic            r_wr_bank;
    logic            r_rd_bank;
    logic [1:0]      r_full;
    logic            r_overflow;
    logic [1:0]      r_state;
    logic [c_KW-1:0] r_k;
    logic            r_out_valid;

    logic            w_handshake;
    logic            w_last_k;
    logic            w_release;
    logic [1:0]      w_free;
    logic            w_wr_en;
    logic            w_drop;
    logic            w_rd_en;
    logic [c_KW-1:0] w_rd_addr;
    logic [IN_W-1:0] w_rd0;
    logic [IN_W-1:0] w_rd1;
    logic [15:0]     w_s0;
    logic [15:0]     w_s1;

    assign w_handshake = r_out_valid & bus.out_ready;
    assign w_last_k    = (r_k == c_KW'(N/2 - 1));
    assign w_release   = (r_state == c_ST_STREAM) & w_handshake & w_last_k;

    // A bank being released on this edge can take a write on the same edge
    assign w_free[0] = ~r_full[0] | (w_release & ~r_rd_bank);
    assign w_free[1] = ~r_full[1] | (w_release &  r_rd_bank);

    assign w_wr_en = bus.in_valid &  w_free[r_wr_bank];
    assign w_drop  = bus.in_valid & ~w_free[r_wr_bank];

    // The write side always alternates banks so frames leave in arrival order;
    // landing on a still-full bank means both are full and input is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_wr_bank  <= 1'b0;
            r_full     <= 2'b00;
            r_overflow <= 1'b0;
        end else begin
            if (w_release) begin
                r_full[r_rd_bank] <= 1'b0;
            end
            if (w_wr_en) begin
                if (r_wr_ptr == c_AW'(N - 1)) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_ptr          <= '0;
                    r_wr_bank         <= ~r_wr_bank;
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = r_k;
        if (r_state == c_ST_LOAD) begin
            w_rd_en = 1'b1;
        end else if ((r_state == c_ST_STREAM) && w_handshake && !w_last_k) begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_k + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_k         <= '0;
            r_rd_bank   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_k <= '0;
                    if (r_full[r_rd_bank]) begin
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    r_out_valid <= 1'b1;
                    r_state     <= c_ST_STREAM;
                end
                c_ST_STREAM: begin
                    if (w_handshake) begin
                        if (w_last_k) begin
                            r_k         <= '0;
                            r_rd_bank   <= ~r_rd_bank;
                            r_out_valid <= 1'b0;
                            r_state     <= r_full[~r_rd_bank] ? c_ST_LOAD : c_ST_IDLE;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    fft_bank_ram #(
        .N (N),
        .W (IN_W)
    ) u_ram (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_wr_en),
        .i_wr_bank   (r_wr_bank),
        .i_wr_addr   (r_wr_ptr),
        .i_wr_data   (bus.in_data),
        .i_rd_en     (w_rd_en),
        .i_rd_bank   (r_rd_bank),
        .i_rd_addr   (w_rd_addr),
        .o_rd_data_0 (w_rd0),
        .o_rd_data_1 (w_rd1)
    );

    if (IN_W < 16) begin : g_sext
        assign w_s0 = {{(16 - IN_W){w_rd0[IN_W-1]}}, w_rd0};
        assign w_s1 = {{(16 - IN_W){w_rd1[IN_W-1]}}, w_rd1};
    end else begin : g_direct
        assign w_s0 = w_rd0[15:0];
        assign w_s1 = w_rd1[15:0];
    end

    assign bus.data_0_real = q16_from_int(w_s0);
    assign bus.data_1_real = q16_from_int(w_s1);
    assign bus.data_0_imag = ZERO;
    assign bus.data_1_imag = ZERO;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_first   = r_out_valid & (r_k == '0);
    assign bus.out_last    = r_out_valid & w_last_k;
    assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: doc/fft_frame_loader.md
# fft_frame_loader

Front-end frame buffer for the FFT datapath. Accepts a serial stream of signed 16-bit real samples, converts each to Q16.16 complex (imaginary zero), collects N-sample frames in a ping-pong buffer, and streams each frame as N/2 sample pairs (x[k], x[k+N/2]) into the first 2-point butterfly stage. Input acceptance continues while the previous frame drains.

## Interface
Parameters:
- N, 16, frame length in points; power of two, 4..256
- IN_W, 16, input sample width (signed two's complement)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data carries a sample this cycle (no backpressure)
- in_data  in  IN_W  signed sample
- out_valid  out  1  pair on data_* is valid
- out_ready  in  1  butterfly stage accepts pair
- data_0_real  out  32  Q16.16, x[k]
- data_0_imag  out  32  always 32'h0
- data_1_real  out  32  Q16.16, x[k+N/2]
- data_1_imag  out  32  always 32'h0
- out_first  out  1  marks pair k=0 of a frame
- out_last  out  1  marks pair k=N/2-1 of a frame
- overflow  out  1  sticky: a sample was dropped

## Operation
- Conversion: real = {in_data, 16'h0000} (IN_W=16), i.e. integer sample value in Q16.16; for IN_W<16 sign-extend to 16 integer bits first. Imag constant zero.
- Two banks, each N × IN_W, written in natural order at wr_ptr (0..N-1). Bank full flag set when sample N-1 is written; wr_ptr wraps to 0 and write side switches to the other bank if that bank is not full.
- Both banks full and in_valid=1: sample discarded, overflow set, wr_ptr unchanged. overflow clears only on rst.
- Read FSM, states IDLE, LOAD, STREAM:
  - IDLE: stay until rd_bank full → LOAD.
  - LOAD: read x[k], x[k+N/2] from rd_bank (k=0) into output registers, assert out_valid → STREAM.
  - STREAM: on out_valid && out_ready, advance k; if k was N/2-1, clear rd_bank full, toggle rd_bank, → LOAD if new rd_bank already full, else IDLE (out_valid drops).
- Output registers hold when out_valid && !out_ready. out_first = (k==0), out_last = (k==N/2-1), both qualified by out_valid.
- Write to a bank and release of the other bank in the same cycle are independent; write-side switch uses the full flags as they stand before that edge's updates except that a bank released this edge counts as free.

## Timing
- Reset values: out_valid 0, out_first 0, out_last 0, overflow 0, data_* 0; wr_ptr 0, wr_bank 0, rd_bank 0, both full flags 0, FSM IDLE.
- Latency: Nth sample captured at edge E → FSM enters LOAD at E+1 → out_valid high after edge E+2.
- With out_ready held high, one pair per cycle; frame drains in N/2 cycles; back-to-back frames insert one LOAD bubble cycle.
- rst mid-frame: partial frame and any pending pairs discarded; first sample after rst is x[0] of bank 0.
- No combinational path in→out; out_ready only affects next-state.

## Structure
- Shared package fft_pkg: DATA_W=32, FRAC_W=16, Q16.16 helper constants (ONE=32'h00010000), default N, twiddle constants used by butterfly stages (W0 etc.).
- One sub-module: fft_bank_ram, dual-bank sample store with one write port and two registered read ports (addresses k, k+N/2).
- FSM state enum local to the block.

## Test plan
- Ramp 0..15 (N=16), out_ready=1 → 8 pairs: (0,8)…(7,15) as 32'h00000000/32'h00080000 … 32'h00070000/32'h000F0000; imag 0; out_first on pair 0, out_last on pair 7; first out_valid 2 cycles after sample 15.
- Negative input in_data=16'hFFFF at x[0] → data_0_real 32'hFFFF0000.
- out_ready low for 5 cycles mid-frame → data_* and flags stable, no pair skipped or duplicated.
- Continuous 48 samples with out_ready=1 → 3 frames output in order, overflow stays 0.
- out_ready=0, 33 samples → frames 0 and 1 buffered, sample 32 dropped, overflow=1; then out_ready=1 → frames 0,1 emitted intact.
- rst asserted after 10 samples, then ramp 100..115 → output pairs (100,108)…(107,115), no stale data.
